// File: rtl/fifo_pop_streamer_pkg.sv
// Shared sizing and helpers for the FIFO pop streamer and its output buffer.
// The buffer depth is fixed at two: the minimum that keeps 1 beat/cycle with a registered pop.
package fifo_pop_streamer_pkg;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = 2;

    typedef logic [CNT_W-1:0] buf_cnt_t;

    // Occupancy update: a simultaneous push and accept leave the count unchanged.
    function automatic buf_cnt_t cnt_next(input buf_cnt_t cnt, input logic inc, input logic dec);
        buf_cnt_t res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + buf_cnt_t'(1);
        end else if (dec && !inc) begin
            res = cnt - buf_cnt_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_out_buffer.sv
// Two-entry registered buffer presenting pushed words as a valid/ready stream.
// The full flag depends only on state, so a producer can gate its push without a ready path.
module stream_out_buffer
    import fifo_pop_streamer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    output logic                  valid,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  accept,
    output buf_cnt_t              count
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic                  wr;
    logic                  rd;
    buf_cnt_t              cnt;
    logic                  push_ok;

    assign full    = (cnt == buf_cnt_t'(BUF_DEPTH));
    assign valid   = (cnt != '0);
    assign data    = mem[rd];
    assign count   = cnt;
    // A clear discards any beat the consumer takes in the same cycle.
    assign accept  = valid & ready & ~clr;
    assign push_ok = push & ~full & ~clr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            wr  <= 1'b0;
            rd  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr <= ~wr;
            end
            if (accept) begin
                rd <= ~rd;
            end
            cnt <= cnt_next(cnt, push_ok, accept);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr] <= push_data;
        end
    end

endmodule

// File: rtl/fifo_pop_streamer.sv
// Drains a FIFO pop port into a valid/ready stream with burst framing on last_o.
// The pop decision looks only at buffer occupancy, never at ready_i.
module fifo_pop_streamer
    import fifo_pop_streamer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  fifo_flush_o,
    input  logic [LEN_WIDTH-1:0]  burst_len_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  busy_o
);

    logic                 push;
    logic                 full;
    logic                 accept;
    buf_cnt_t             count;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cur_len;

    assign push         = ~fifo_empty_i & ~full & ~flush_i & ~rst_i;
    assign fifo_pop_o   = push;
    assign fifo_flush_o = flush_i;

    stream_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .clr       (flush_i),
        .push      (push),
        .push_data (fifo_data_i),
        .full      (full),
        .valid     (valid_o),
        .ready     (ready_i),
        .data      (data_o),
        .accept    (accept),
        .count     (count)
    );

    // The burst length is taken live on the first beat and held for the rest of the burst.
    assign cur_len = (beat_cnt == '0) ? burst_len_i : len_q;
    assign last_o  = valid_o & (beat_cnt == cur_len);
    assign busy_o  = (count != '0) | (beat_cnt != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt <= '0;
            len_q    <= '0;
        end else if (flush_i) begin
            beat_cnt <= '0;
        end else if (accept) begin
            if (beat_cnt == '0) begin
                len_q <= burst_len_i;
            end
            beat_cnt <= last_o ? '0 : beat_cnt + LEN_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_pop_streamer.sv
// Directed and random checks of fifo_pop_streamer against a FIFO model and scoreboard.
module tb_fifo_pop_streamer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        fifo_empty_i;
    logic [31:0] fifo_data_i;
    logic        fifo_pop_o;
    logic        fifo_flush_o;
    logic [7:0]  burst_len_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        last_o;
    logic        busy_o;

    fifo_pop_streamer #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .fifo_flush_o (fifo_flush_o),
        .burst_len_i  (burst_len_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .last_o       (last_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        rst;
        logic        empty;
        logic [31:0] fdata;
        logic        ready;
        logic        pop;
        logic        valid;
        logic        last;
        logic        busy;
        logic [31:0] data;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] fq[$];
    logic [31:0] exp_q[$];
    logic        use_model = 1'b0;
    logic        stall = 1'b0;
    int          mcnt = 0;
    int          mlen = 0;
    int          beats = 0;
    int          nlast = 0;
    int          last_beat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic empty, input logic [31:0] fdata,
                                input logic ready, input logic pop, input logic valid,
                                input logic last, input logic busy, input logic [31:0] data);
        vec_t v;
        v.rst = rst; v.empty = empty; v.fdata = fdata; v.ready = ready;
        v.pop = pop; v.valid = valid; v.last = last; v.busy = busy; v.data = data;
        return v;
    endfunction

    // Drive the FIFO head from the model and let combinational outputs settle.
    task automatic settle();
        if (use_model) begin
            fifo_empty_i = stall || (fq.size() == 0);
            fifo_data_i  = (fq.size() != 0) ? fq[0] : 32'h0;
        end
        #1;
    endtask

    // Score this cycle's handshake and pop, then advance one clock.
    task automatic commit();
        int  cur;
        logic el;
        logic [31:0] ed;
        if (use_model) begin
            if (rst_i || flush_i) begin
                exp_q.delete();
                mcnt = 0;
                if (fifo_pop_o) chk("pop_during_clear", fifo_pop_o, 1'b0);
            end else begin
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_beat", valid_o, 1'b0);
                    end else begin
                        ed = exp_q.pop_front();
                        chk("beat_data", data_o, ed);
                        cur = (mcnt == 0) ? int'(burst_len_i) : mlen;
                        if (mcnt == 0) mlen = int'(burst_len_i);
                        el = (mcnt == cur);
                        chk("beat_last", last_o, el);
                        beats++;
                        if (el) begin
                            nlast++;
                            last_beat = beats;
                            mcnt = 0;
                        end else begin
                            mcnt++;
                        end
                    end
                end
                if (fifo_pop_o) begin
                    chk("pop_nonempty", fifo_empty_i, 1'b0);
                    if (!fifo_empty_i && fq.size() != 0) exp_q.push_back(fq.pop_front());
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_beats(input int n, input int budget, input string name);
        int b0;
        int c;
        b0 = beats;
        c = 0;
        while ((beats - b0) < n && c < budget) begin
            settle();
            commit();
            c++;
        end
        chk(name, beats - b0, n);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        settle();
        commit();
        rst_i = 1'b0;
    endtask

    vec_t tbl[13];

    initial begin
        int pops;
        int first;
        int lastc;
        int cyc;
        int b0;
        int nl0;
        logic [31:0] word;

        rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0; burst_len_i = 8'd1;
        fifo_empty_i = 1'b1; fifo_data_i = 32'h0;

        // burst_len_i = 1 throughout: two-beat bursts
        //            rst   empty fdata     rdy   pop   vld   last  busy  data
        tbl[0]  = mk(1'b1, 1'b0, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 1'b0, 32'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[3]  = mk(1'b0, 1'b0, 32'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0);
        tbl[4]  = mk(1'b0, 1'b0, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA0);
        tbl[5]  = mk(1'b0, 1'b0, 32'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA0);
        tbl[6]  = mk(1'b0, 1'b0, 32'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA1);
        tbl[7]  = mk(1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA2);
        tbl[8]  = mk(1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tbl[9]  = mk(1'b0, 1'b0, 32'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        tbl[10] = mk(1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA3);
        tbl[11] = mk(1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA3);
        tbl[12] = mk(1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        @(posedge clk_i);
        #1;
        for (int i = 0; i < 13; i++) begin
            rst_i = tbl[i].rst;
            fifo_empty_i = tbl[i].empty;
            fifo_data_i = tbl[i].fdata;
            ready_i = tbl[i].ready;
            #1;
            chk($sformatf("vec%0d_pop", i), fifo_pop_o, tbl[i].pop);
            chk($sformatf("vec%0d_valid", i), valid_o, tbl[i].valid);
            chk($sformatf("vec%0d_last", i), last_o, tbl[i].last);
            chk($sformatf("vec%0d_busy", i), busy_o, tbl[i].busy);
            if (tbl[i].valid) chk($sformatf("vec%0d_data", i), data_o, tbl[i].data);
            @(posedge clk_i);
            #1;
        end

        // Streaming: 8 beats at full rate, two bursts of four.
        use_model = 1'b1;
        do_reset();
        burst_len_i = 8'd3;
        ready_i = 1'b1;
        for (int w = 0; w < 8; w++) fq.push_back(32'h10 + w);
        first = -1; lastc = -1; cyc = 0; b0 = beats; nl0 = nlast;
        while ((beats - b0) < 8 && cyc < 40) begin
            settle();
            if (cyc == 0) chk("stream_first_pop", fifo_pop_o, 1'b1);
            if (cyc == 1) chk("stream_first_valid", valid_o, 1'b1);
            if (valid_o && ready_i) begin
                if (first < 0) first = cyc;
                lastc = cyc;
            end
            commit();
            cyc++;
        end
        chk("stream_beats", beats - b0, 8);
        chk("stream_no_bubble", lastc - first, 7);
        chk("stream_lasts", nlast - nl0, 2);

        // Backpressure: only two pops while stalled, head word held.
        ready_i = 1'b0;
        for (int w = 0; w < 8; w++) fq.push_back(32'h20 + w);
        pops = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            if (fifo_pop_o) pops++;
            if (c >= 1) chk("bp_data_stable", data_o, 32'h20);
            if (c >= 1) chk("bp_valid_held", valid_o, 1'b1);
            commit();
        end
        chk("bp_pops", pops, 2);
        ready_i = 1'b1;
        run_beats(8, 40, "bp_drain");
        chk("bp_sb_empty", exp_q.size(), 0);

        // Length edges.
        burst_len_i = 8'd0;
        for (int w = 0; w < 4; w++) fq.push_back(32'h30 + w);
        nl0 = nlast;
        run_beats(4, 20, "len0_beats");
        chk("len0_lasts", nlast - nl0, 4);

        burst_len_i = 8'd255;
        for (int w = 0; w < 256; w++) fq.push_back(32'h1000 + w);
        nl0 = nlast;
        run_beats(256, 600, "len255_beats");
        chk("len255_lasts", nlast - nl0, 1);
        chk("len255_last_pos", last_beat, beats);

        burst_len_i = 8'd3;
        for (int w = 0; w < 4; w++) fq.push_back(32'h60 + w);
        nl0 = nlast;
        run_beats(1, 20, "lenchg_first");
        burst_len_i = 8'd1;
        run_beats(3, 20, "lenchg_rest");
        chk("lenchg_lasts", nlast - nl0, 1);
        chk("lenchg_last_pos", last_beat, beats);

        // Flush with a full buffer mid-burst and a concurrent handshake.
        burst_len_i = 8'd7;
        for (int w = 0; w < 10; w++) fq.push_back(32'h40 + w);
        run_beats(2, 20, "flush_pre_beats");
        ready_i = 1'b0;
        cyc = 0;
        settle();
        while (fifo_pop_o && cyc < 4) begin
            commit();
            settle();
            cyc++;
        end
        chk("flush_pre_full", fifo_pop_o, 1'b0);
        chk("flush_pre_busy", busy_o, 1'b1);
        commit();
        flush_i = 1'b1;
        ready_i = 1'b1;
        settle();
        chk("flush_fifo_flush", fifo_flush_o, 1'b1);
        chk("flush_no_pop", fifo_pop_o, 1'b0);
        commit();
        flush_i = 1'b0;
        fq.delete();
        stall = 1'b1;
        settle();
        chk("flush_valid_cleared", valid_o, 1'b0);
        chk("flush_busy_cleared", busy_o, 1'b0);
        chk("flush_fifo_flush_off", fifo_flush_o, 1'b0);
        commit();
        stall = 1'b0;
        burst_len_i = 8'd1;
        fq.push_back(32'h50);
        fq.push_back(32'h51);
        nl0 = nlast;
        b0 = beats;
        run_beats(2, 20, "flush_post_beats");
        chk("flush_post_lasts", nlast - nl0, 1);
        chk("flush_post_last_pos", last_beat - b0, 2);

        // Random traffic against the scoreboard.
        word = 32'h8000_0000;
        b0 = beats;
        cyc = 0;
        while ((beats - b0) < 10000 && cyc < 60000) begin
            while (fq.size() < 4) begin
                fq.push_back(word);
                word = word + 32'd1;
            end
            stall = ($urandom_range(0, 9) < 3);
            ready_i = ($urandom_range(0, 9) < 7);
            burst_len_i = 8'($urandom_range(0, 5));
            settle();
            commit();
            cyc++;
        end
        chk("rand_beats", beats - b0, 10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
